// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
// Write-side controller of a gray-pointer async FIFO. Advances the binary
// write pointer on accepted writes and drives the RAM write port. Publishes
// a flop-direct gray write pointer for the read-domain synchronizer. Derives
// full, almost-full, fill level and a sticky overflow flag against the read
// pointer that has already been synchronized into this clock domain.
//
// The flags compare against a synchronized read pointer that lags the real
// one. As a result they are pessimistic: full may linger and the level may
// over-report, but neither ever under-reports.

module fifo_wr_ctrl #(
    parameter int FIFO_addr_size = 2,
    parameter int ALMOST_FULL_TH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      winc,
    input  logic                      ovf_clr,
    input  logic [FIFO_addr_size:0]   rptr_sync,
    output logic                      wen,
    output logic [FIFO_addr_size-1:0] waddr,
    output logic [FIFO_addr_size:0]   wptr,
    output logic                      wfull,
    output logic                      walmost_full,
    output logic [FIFO_addr_size:0]   wlevel,
    output logic                      overflow
);

    localparam int A = FIFO_addr_size;

    // Registered state
    logic [A:0] wbin_reg;
    logic [A:0] wptr_reg;
    logic       wfull_reg;
    logic       walmost_full_reg;
    logic [A:0] wlevel_reg;
    logic       overflow_reg;

    // Next-state values
    logic       acc;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic       wfull_next;
    logic       walmost_full_next;
    logic [A:0] wlevel_next;
    logic       overflow_next;

    // Derived read-side values
    logic [A:0] rbin;
    logic [A:0] full_cmp;

    // A write is accepted only when the FIFO is not already full
    assign acc = winc & ~wfull_reg;

    // Binary write pointer increments modulo 2^(A+1) on an accepted write
    assign wbin_next = wbin_reg + {{A{1'b0}}, acc};

    // Binary-to-gray conversion of the next write pointer, bit by bit
    genvar gi;
    generate
        for (gi = 0; gi < A; gi++) begin : g_bin2gray
            assign wgray_next[gi] = wbin_next[gi+1] ^ wbin_next[gi];
        end
    endgenerate
    assign wgray_next[A] = wbin_next[A];

    // Gray-to-binary conversion of the synchronized read pointer:
    // XOR prefix running down from the MSB
    assign rbin[A] = rptr_sync[A];
    generate
        for (gi = A - 1; gi >= 0; gi--) begin : g_gray2bin
            assign rbin[gi] = rbin[gi+1] ^ rptr_sync[gi];
        end
    endgenerate

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer. In gray code, that means the top two bits are inverted and
    // the rest are equal.
    assign full_cmp = {~rptr_sync[A:A-1], rptr_sync[A-2:0]};

    // Next-value computation for the flags and the occupancy
    always_comb begin
        wfull_next        = (wgray_next == full_cmp);
        wlevel_next       = wbin_next - rbin;
        walmost_full_next = (32'(wlevel_next) >= 32'(ALMOST_FULL_TH));
    end

    // Sticky overflow: a refused write sets it, clear acts only when no set
    always_comb begin
        overflow_next = overflow_reg;
        if (winc && wfull_reg) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    // Pointer and flag registers, all cleared immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin_reg         <= '0;
            wptr_reg         <= '0;
            wfull_reg        <= 1'b0;
            walmost_full_reg <= 1'b0;
            wlevel_reg       <= '0;
            overflow_reg     <= 1'b0;
        end else begin
            wbin_reg         <= wbin_next;
            wptr_reg         <= wgray_next;
            wfull_reg        <= wfull_next;
            walmost_full_reg <= walmost_full_next;
            wlevel_reg       <= wlevel_next;
            overflow_reg     <= overflow_next;
        end
    end

    // RAM write port is combinational, valid in the same cycle as winc
    assign wen   = acc;
    assign waddr = wbin_reg[A-1:0];

    // wptr comes straight from a flop: it is sampled by another clock domain
    assign wptr         = wptr_reg;
    assign wfull        = wfull_reg;
    assign walmost_full = walmost_full_reg;
    assign wlevel       = wlevel_reg;
    assign overflow     = overflow_reg;

endmodule
